// File: rtl/fft_pkg.sv
// Shared constants, complex sample type and bit-reversal helper for the FFT input path.
package fft_pkg;

    localparam int DATA_WIDTH = 20;
    localparam int N          = 16;
    localparam int LOG2N      = 4;

    typedef struct packed {
        logic signed [DATA_WIDTH-1:0] re;
        logic signed [DATA_WIDTH-1:0] im;
    } cplx_t;

    // Mirror the LOG2N-bit index so that MSB becomes LSB.
    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] idx);
        logic [LOG2N-1:0] res;
        res = {LOG2N{1'b0}};
        for (int b = 0; b < LOG2N; b++) begin
            res[b] = idx[LOG2N-1-b];
        end
        return res;
    endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One N-entry sample bank: synchronous write port, asynchronous read port.
module fft_frame_bank
    import fft_pkg::*;
#(
    parameter int DEPTH = fft_pkg::N,
    parameter int AW    = fft_pkg::LOG2N
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  cplx_t         wdata,
    input  logic [AW-1:0] raddr,
    output cplx_t         rdata
);

    cplx_t mem_r [DEPTH];

    // Storage write; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/fft_input_reorder.sv
// Ping-pong bank pair turning natural-order input frames into bit-reversed output frames.
// Optional macro FFT_REORDER_FRAME_CNT_EN adds the frame_cnt output port.
module fft_input_reorder
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = fft_pkg::DATA_WIDTH,
    parameter int N          = fft_pkg::N,
    parameter int LOG2N      = fft_pkg::LOG2N
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_real,
    input  logic [DATA_WIDTH-1:0] in_imag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_real,
    output logic [DATA_WIDTH-1:0] out_imag,
    output logic [LOG2N-1:0]      out_idx,
    output logic                  out_sof,
    output logic                  out_eof
`ifdef FFT_REORDER_FRAME_CNT_EN
    ,
    output logic [15:0]           frame_cnt
`endif
);

    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);
    localparam logic [LOG2N-1:0] ZERO_IDX = {LOG2N{1'b0}};
    localparam logic [LOG2N-1:0] ONE_IDX  = LOG2N'(1);

    logic             wr_bank_r;
    logic             rd_bank_r;
    logic [LOG2N-1:0] wr_cnt_r;
    logic [LOG2N-1:0] rd_cnt_r;
    logic [1:0]       full_r;
    logic [1:0]       full_nxt_s;
    logic             wr_hs_s;
    logic             rd_hs_s;
    logic             wr_last_s;
    logic             rd_last_s;
    logic [1:0]       we_s;
    logic [LOG2N-1:0] rd_addr_s;
    cplx_t            wdata_s;
    cplx_t            rdata0_s;
    cplx_t            rdata1_s;
    cplx_t            rdata_s;

    assign in_ready  = ~full_r[wr_bank_r];
    assign out_valid = full_r[rd_bank_r];
    assign wr_hs_s   = in_valid & in_ready;
    assign rd_hs_s   = out_valid & out_ready;
    assign wr_last_s = wr_hs_s & (wr_cnt_r == LAST_IDX);
    assign rd_last_s = rd_hs_s & (rd_cnt_r == LAST_IDX);
    assign rd_addr_s = bitrev(rd_cnt_r);
    assign wdata_s   = '{re: in_real, im: in_imag};
    assign we_s      = {wr_hs_s & wr_bank_r, wr_hs_s & ~wr_bank_r};

    fft_frame_bank #(.DEPTH(N), .AW(LOG2N)) u_bank0 (
        .clk   (clk),
        .we    (we_s[0]),
        .waddr (wr_cnt_r),
        .wdata (wdata_s),
        .raddr (rd_addr_s),
        .rdata (rdata0_s)
    );

    fft_frame_bank #(.DEPTH(N), .AW(LOG2N)) u_bank1 (
        .clk   (clk),
        .we    (we_s[1]),
        .waddr (wr_cnt_r),
        .wdata (wdata_s),
        .raddr (rd_addr_s),
        .rdata (rdata1_s)
    );

    // Select the draining bank and apply the full-flag set/clear of this cycle.
    always_comb begin
        full_nxt_s = full_r;
        rdata_s    = rdata0_s;
        if (rd_bank_r) begin
            rdata_s = rdata1_s;
        end else begin
            rdata_s = rdata0_s;
        end
        // Final write and final read always hit different banks, so both may apply.
        if (wr_last_s) begin
            full_nxt_s[wr_bank_r] = 1'b1;
        end else begin
            full_nxt_s[wr_bank_r] = full_r[wr_bank_r];
        end
        if (rd_last_s) begin
            full_nxt_s[rd_bank_r] = 1'b0;
        end else begin
            full_nxt_s[rd_bank_r] = full_nxt_s[rd_bank_r];
        end
    end

    assign out_real = rdata_s.re;
    assign out_imag = rdata_s.im;
    assign out_idx  = rd_cnt_r;
    assign out_sof  = out_valid & (rd_cnt_r == ZERO_IDX);
    assign out_eof  = out_valid & (rd_cnt_r == LAST_IDX);

    // Write/read counters, bank pointers and full flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank_r <= 1'b0;
            rd_bank_r <= 1'b0;
            wr_cnt_r  <= ZERO_IDX;
            rd_cnt_r  <= ZERO_IDX;
            full_r    <= 2'b00;
        end else begin
            full_r <= full_nxt_s;
            if (wr_last_s) begin
                wr_cnt_r  <= ZERO_IDX;
                wr_bank_r <= ~wr_bank_r;
            end else if (wr_hs_s) begin
                wr_cnt_r  <= wr_cnt_r + ONE_IDX;
            end
            if (rd_last_s) begin
                rd_cnt_r  <= ZERO_IDX;
                rd_bank_r <= ~rd_bank_r;
            end else if (rd_hs_s) begin
                rd_cnt_r  <= rd_cnt_r + ONE_IDX;
            end
        end
    end

`ifdef FFT_REORDER_FRAME_CNT_EN
    // Count frames fully handed downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= 16'd0;
        end else if (rd_hs_s && out_eof) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule
